// File: rtl/reg_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter_if
//   Writeback bus between the two requesters (ALU pipe, load/store unit), the
//   arbiter, and the register file write port.
//
//   Signals
//     Alu_Wr_Valid/Addr/Data  ALU writeback request (held until Ready)
//     Alu_Wr_Ready            ALU request granted this cycle
//     Lsu_Wr_Valid/Addr/Data  load-return writeback request (held until Ready)
//     Lsu_Wr_Ready            LSU request granted this cycle
//     Rf_Wr_En/Addr/Data      registered register file write port
//
//   Modports
//     master  requester / register-file side (drives requests, sees grants)
//     slave   arbiter side (consumes requests, drives grants and write port)
// ---------------------------------------------------------------------------
interface reg_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              Alu_Wr_Valid;
  logic [ADDR_W-1:0] Alu_Wr_Addr;
  logic [DATA_W-1:0] Alu_Wr_Data;
  logic              Alu_Wr_Ready;

  logic              Lsu_Wr_Valid;
  logic [ADDR_W-1:0] Lsu_Wr_Addr;
  logic [DATA_W-1:0] Lsu_Wr_Data;
  logic              Lsu_Wr_Ready;

  logic              Rf_Wr_En;
  logic [ADDR_W-1:0] Rf_Wr_Addr;
  logic [DATA_W-1:0] Rf_Wr_Data;

  modport master (
    output Alu_Wr_Valid, Alu_Wr_Addr, Alu_Wr_Data,
    output Lsu_Wr_Valid, Lsu_Wr_Addr, Lsu_Wr_Data,
    input  Alu_Wr_Ready, Lsu_Wr_Ready,
    input  Rf_Wr_En, Rf_Wr_Addr, Rf_Wr_Data
  );

  modport slave (
    input  Alu_Wr_Valid, Alu_Wr_Addr, Alu_Wr_Data,
    input  Lsu_Wr_Valid, Lsu_Wr_Addr, Lsu_Wr_Data,
    output Alu_Wr_Ready, Lsu_Wr_Ready,
    output Rf_Wr_En, Rf_Wr_Addr, Rf_Wr_Data
  );

endinterface

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Owns the single write port of the GP register file. After reset it sweeps
//   INIT_VALUE into x1..x(NUM_REGS-1), one register per cycle, then arbitrates
//   writeback between the ALU and the LSU. LSU has fixed priority; an ALU
//   request that has been stalled STARVE_MAX consecutive cycles is forced
//   through. Writes to x0 are accepted but never reach the register file.
//
//   Ports
//     Clk_Core   in   core clock, rising edge
//     Rst_Core   in   asynchronous reset, active-high
//     Init_Busy  out  1 while the init sweep is in progress
//     Wr_Bus     slave side of reg_write_arbiter_if (requests, grants,
//                registered register file write port)
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 5,
  parameter int unsigned       NUM_REGS   = 32,
  parameter int unsigned       STARVE_MAX = 3,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core,
  output logic                 Init_Busy,
  reg_write_arbiter_if.slave   Wr_Bus
);

  localparam int unsigned       CNT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_MAX);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_starve;
  logic              r_rf_en;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic              w_alu_valid;
  logic              w_lsu_valid;
  logic              w_starved;
  logic              w_alu_ready;
  logic              w_lsu_ready;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  assign w_alu_valid = Wr_Bus.Alu_Wr_Valid;
  assign w_lsu_valid = Wr_Bus.Lsu_Wr_Valid;
  assign w_starved   = (r_starve == CNT_MAX);

  // Grant decision. Both readies stay low during the sweep so requesters
  // simply keep holding their requests until RUN.
  always_comb begin
    w_alu_ready = 1'b0;
    w_lsu_ready = 1'b0;
    if (r_state == ST_RUN) begin
      if (w_starved && w_alu_valid) begin
        w_alu_ready = 1'b1;
      end else if (w_lsu_valid) begin
        w_lsu_ready = 1'b1;
      end else if (w_alu_valid) begin
        w_alu_ready = 1'b1;
      end
    end
  end

  // Readies are one-hot and never raised without valid, so the ready itself
  // selects the winning payload.
  assign w_xfer     = w_alu_ready | w_lsu_ready;
  assign w_sel_addr = w_lsu_ready ? Wr_Bus.Lsu_Wr_Addr : Wr_Bus.Alu_Wr_Addr;
  assign w_sel_data = w_lsu_ready ? Wr_Bus.Lsu_Wr_Data : Wr_Bus.Alu_Wr_Data;

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      r_state   <= ST_INIT;
      r_ptr     <= ADDR_W'(1);
      r_starve  <= '0;
      r_rf_en   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rf_en   <= 1'b1;
          r_rf_addr <= r_ptr;
          r_rf_data <= INIT_VALUE;
          r_ptr     <= r_ptr + ADDR_W'(1);
          r_starve  <= '0;
          if (r_ptr == LAST_ADDR) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Write port pulses for one cycle per transfer; address and data
          // keep their last value otherwise. A transfer to x0 is consumed
          // but leaves the write port idle.
          r_rf_en <= 1'b0;
          if (w_xfer && (w_sel_addr != '0)) begin
            r_rf_en   <= 1'b1;
            r_rf_addr <= w_sel_addr;
            r_rf_data <= w_sel_data;
          end

          // Consecutive ALU stall cycles, saturating; any cycle without an
          // ALU request or with an ALU grant restarts the count.
          if (w_alu_valid && !w_alu_ready) begin
            if (!w_starved) begin
              r_starve <= r_starve + CNT_W'(1);
            end
          end else begin
            r_starve <= '0;
          end
        end

        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign Init_Busy           = (r_state == ST_INIT);
  assign Wr_Bus.Alu_Wr_Ready = w_alu_ready;
  assign Wr_Bus.Lsu_Wr_Ready = w_lsu_ready;
  assign Wr_Bus.Rf_Wr_En     = r_rf_en;
  assign Wr_Bus.Rf_Wr_Addr   = r_rf_addr;
  assign Wr_Bus.Rf_Wr_Data   = r_rf_data;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter. Expected register-file writes are
//   queued when a request is driven and popped when the write port shows a
//   write; grants are checked against directed expectations each step.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [36:0] sb[$];

  reg_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_write_arbiter #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .NUM_REGS  (32),
    .STARVE_MAX(3),
    .INIT_VALUE(32'h0)
  ) u_dut (
    .Clk_Core (clk),
    .Rst_Core (rst),
    .Init_Busy(init_busy),
    .Wr_Bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [36:0] e;
    chk({tag, "_sb_avail"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_addr"}, 32'(bus.Rf_Wr_Addr), 32'(e[36:32]));
      chk({tag, "_data"}, bus.Rf_Wr_Data, e[31:0]);
    end
  endtask

  // One RUN cycle: drive requests, check grants before the edge, check the
  // write port after it.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic exp_ar, input logic exp_lr, input string tag);
    logic exp_en;
    bus.Alu_Wr_Valid = av;
    bus.Alu_Wr_Addr  = aa;
    bus.Alu_Wr_Data  = ad;
    bus.Lsu_Wr_Valid = lv;
    bus.Lsu_Wr_Addr  = la;
    bus.Lsu_Wr_Data  = ld;
    exp_en = 1'b0;
    if (exp_lr && la != 5'd0) begin
      sb.push_back({la, ld});
      exp_en = 1'b1;
    end else if (exp_ar && aa != 5'd0) begin
      sb.push_back({aa, ad});
      exp_en = 1'b1;
    end
    #1;
    chk({tag, "_alu_rdy"}, 32'(bus.Alu_Wr_Ready), 32'(exp_ar));
    chk({tag, "_lsu_rdy"}, 32'(bus.Lsu_Wr_Ready), 32'(exp_lr));
    @(negedge clk);
    chk({tag, "_en"}, 32'(bus.Rf_Wr_En), 32'(exp_en));
    chk({tag, "_busy"}, 32'(init_busy), 32'd0);
    if (exp_en) pop_chk(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, tag);
  endtask

  // Releases reset and follows the first n sweep writes. An LSU request is
  // held during the sweep to show it is not granted.
  task automatic sweep(input int unsigned n, input string tag);
    rst = 1'b0;
    bus.Alu_Wr_Valid = 1'b0;
    bus.Lsu_Wr_Valid = 1'b1;
    bus.Lsu_Wr_Addr  = 5'd2;
    bus.Lsu_Wr_Data  = 32'h0BAD;
    for (int unsigned i = 1; i <= n; i++) begin
      sb.push_back({5'(i), 32'h0});
      @(negedge clk);
      chk({tag, "_en"}, 32'(bus.Rf_Wr_En), 32'd1);
      pop_chk(tag);
      chk({tag, "_busy"}, 32'(init_busy), 32'(i < 31));
      chk({tag, "_alu_rdy"}, 32'(bus.Alu_Wr_Ready), 32'd0);
      chk({tag, "_lsu_rdy"}, 32'(bus.Lsu_Wr_Ready), 32'd0);
      if (i == 30) bus.Lsu_Wr_Valid = 1'b0;
    end
    bus.Lsu_Wr_Valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(init_busy), 32'd1);
    chk({tag, "_en"}, 32'(bus.Rf_Wr_En), 32'd0);
    chk({tag, "_addr"}, 32'(bus.Rf_Wr_Addr), 32'd0);
    chk({tag, "_data"}, bus.Rf_Wr_Data, 32'd0);
    chk({tag, "_alu_rdy"}, 32'(bus.Alu_Wr_Ready), 32'd0);
    chk({tag, "_lsu_rdy"}, 32'(bus.Lsu_Wr_Ready), 32'd0);
  endtask

  initial begin
    bus.Alu_Wr_Valid = 1'b1;
    bus.Alu_Wr_Addr  = 5'd1;
    bus.Alu_Wr_Data  = 32'h1;
    bus.Lsu_Wr_Valid = 1'b1;
    bus.Lsu_Wr_Addr  = 5'd1;
    bus.Lsu_Wr_Data  = 32'h1;

    // Reset for 3 cycles, then the full sweep.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst");
    sweep(31, "sweep1");

    // Single ALU write, then idle: enable drops, address/data hold.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "alu_only");
    idle("alu_only_idle");
    chk("hold_addr", 32'(bus.Rf_Wr_Addr), 32'd5);
    chk("hold_data", bus.Rf_Wr_Data, 32'hDEADBEEF);

    // Both valid: LSU first, ALU next cycle.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, "both_lsu");
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, "both_alu");
    idle("both_idle");

    // Continuous LSU stream: ALU stalls 3 cycles, wins the 4th, LSU resumes.
    for (int k = 0; k < 4; k++)
      step(1'b1, 5'd7, 32'hA7, 1'b1, 5'(8 + k), 32'(100 + k),
           1'(k == 3), 1'(k != 3), "starve_a");
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'd104, 1'b0, 1'b1, "starve_resume");

    // ALU dropping its request clears the stall count.
    step(1'b1, 5'd7, 32'hB7, 1'b1, 5'd13, 32'd200, 1'b0, 1'b1, "starve_b0");
    step(1'b1, 5'd7, 32'hB7, 1'b1, 5'd14, 32'd201, 1'b0, 1'b1, "starve_b1");
    step(1'b0, 5'd0, 32'h0,  1'b1, 5'd15, 32'd202, 1'b0, 1'b1, "starve_gap");
    for (int k = 0; k < 4; k++)
      step(1'b1, 5'd7, 32'hC7, 1'b1, 5'(16 + k), 32'(300 + k),
           1'(k == 3), 1'(k != 3), "starve_c");
    idle("starve_idle");

    // Write to x0 is consumed without enabling the register file.
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "x0_write");
    idle("x0_idle");

    // Same address on both ports: LSU then ALU, later write last.
    step(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0, 1'b1, "same_lsu");
    step(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "same_alu");
    idle("same_idle");

    // Reset mid-RUN with a granted ALU request in flight.
    bus.Alu_Wr_Valid = 1'b1;
    bus.Alu_Wr_Addr  = 5'd6;
    bus.Alu_Wr_Data  = 32'h66;
    #1;
    chk("inflight_rdy", 32'(bus.Alu_Wr_Ready), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_state("rst_run");
    bus.Alu_Wr_Valid = 1'b0;
    @(negedge clk);
    chk("rst_run_dropped", 32'(bus.Rf_Wr_En), 32'd0);
    sb.delete();
    @(negedge clk);
    sweep(10, "sweep2");

    // Reset mid-INIT at Addr=10, sweep restarts at x1.
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state("rst_init");
    sb.delete();
    repeat (2) @(negedge clk);
    sweep(31, "sweep3");
    idle("post_sweep");
    step(1'b1, 5'd31, 32'h31, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "final_alu");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
